// File: rtl/wisc_pkg.sv
// Shared definitions for the pipeline: opcodes, MEM-stage FSM encoding and
// the register-write decode used when loading MEM/WB.
package wisc_pkg;

  localparam logic [3:0] OpLw = 4'b1000;
  localparam logic [3:0] OpSw = 4'b1001;

  localparam int unsigned TimeoutDefault = 255;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  // Stores, branches and the 1100/1101/1111 group never write the register file.
  function automatic logic writes_reg(logic [3:0] op);
    logic we;
    case (op)
      4'b1001, 4'b1100, 4'b1101, 4'b1111: we = 1'b0;
      default:                            we = 1'b1;
    endcase
    return we;
  endfunction

  function automatic logic is_mem_op(logic [3:0] op);
    return (op == OpLw) || (op == OpSw);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/completion bus between the MEM stage and data memory.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_wb.sv
// MEM/WB pipeline register; a bubble load clears valid, we, rd and data.
module mem_wb (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        bubble,
  input  logic        we,
  input  logic [3:0]  rd,
  input  logic [15:0] data,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [3:0]  wb_rd,
  output logic [15:0] wb_data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= 4'd0;
      wb_data  <= 16'd0;
    end else if (en) begin
      wb_valid <= !bubble;
      wb_we    <= !bubble && we;
      wb_rd    <= bubble ? 4'd0 : rd;
      wb_data  <= bubble ? 16'd0 : data;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU results through in one cycle and runs
// LW/SW accesses on the data-memory bus with a wait-state timeout.
module mem_stage
  import wisc_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [3:0]         op_i,
  input  logic [3:0]         rd_i,
  input  logic               br_i,
  input  logic [15:0]        mem_addr_i,
  input  logic [15:0]        alu_data_i,
  input  logic [15:0]        st_data_i,
  output logic               stall_o,
  mem_stage_if.master        dm,
  output logic               wb_valid_o,
  output logic               wb_we_o,
  output logic [3:0]         wb_rd_o,
  output logic [15:0]        wb_data_o,
  output logic               err_o
);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, cnt_q, cnt_d;
  logic [3:0]  op_q, op_d, rd_q, rd_d;
  logic        err_q, err_d;
  logic        stall;
  logic        wb_en, wb_bubble, wb_we_n;
  logic [3:0]  wb_rd_n;
  logic [15:0] wb_data_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      cnt_q   <= 16'd0;
      op_q    <= 4'd0;
      rd_q    <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    err_d     = err_q;
    stall     = 1'b0;
    wb_en     = 1'b0;
    wb_bubble = 1'b1;
    wb_we_n   = 1'b0;
    wb_rd_n   = 4'd0;
    wb_data_n = 16'd0;
    unique case (state_q)
      StIdle: begin
        wb_en = 1'b1;
        if (valid_i && !br_i) begin
          if (is_mem_op(op_i)) begin
            addr_d  = mem_addr_i;
            wdata_d = st_data_i;
            op_d    = op_i;
            rd_d    = rd_i;
            cnt_d   = 16'd0;
            state_d = StBusy;
            stall   = 1'b1;
          end else begin
            wb_bubble = 1'b0;
            wb_we_n   = writes_reg(op_i);
            wb_rd_n   = rd_i;
            wb_data_n = alu_data_i;
          end
        end
      end
      StBusy: begin
        stall = !dm.ack;
        // Ack has priority over an expiring wait counter.
        if (dm.ack) begin
          state_d   = StIdle;
          wb_en     = 1'b1;
          wb_bubble = 1'b0;
          wb_we_n   = writes_reg(op_q);
          wb_rd_n   = rd_q;
          wb_data_n = (op_q == OpLw) ? dm.rdata : wdata_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == 16'(TIMEOUT - 1)) begin
            state_d = StIdle;
            wb_en   = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign stall_o  = rst && stall;
  assign dm.req   = (state_q == StBusy);
  assign dm.we    = (state_q == StBusy) && (op_q == OpSw);
  assign dm.addr  = addr_q;
  assign dm.wdata = wdata_q;
  assign err_o    = err_q;

  mem_wb u_mem_wb (
    .clk      (clk),
    .rst      (rst),
    .en       (wb_en),
    .bubble   (wb_bubble),
    .we       (wb_we_n),
    .rd       (wb_rd_n),
    .data     (wb_data_n),
    .wb_valid (wb_valid_o),
    .wb_we    (wb_we_o),
    .wb_rd    (wb_rd_o),
    .wb_data  (wb_data_o)
  );

endmodule
